// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the SRAM port-0 controller slice.
package sram_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_WB = 1'b0,
    GRANT_LA = 1'b1
  } grant_t;

  // Reads drive an all-zero byte mask so the macro never sees stray write lanes.
  function automatic logic [MASK_W-1:0] issue_mask(input logic we,
                                                   input logic [MASK_W-1:0] mask);
    return we ? mask : '0;
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered last winner.
module sram_rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   req_wb,
  input  logic   req_la,
  output logic   gnt_valid,
  output grant_t gnt
);

  grant_t last_grant;

  always_comb begin
    gnt_valid = en && (req_wb || req_la);
    if (req_wb && req_la)
      gnt = (last_grant == GRANT_WB) ? GRANT_LA : GRANT_WB;
    else if (req_la)
      gnt = GRANT_LA;
    else
      gnt = GRANT_WB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= GRANT_LA;
    else if (gnt_valid)
      last_grant <= gnt;
  end

endmodule

// File: rtl/sram_port0_arbiter.sv
// Shares SRAM RW port 0 between the Wishbone slave and the LA test port;
// all macro inputs come straight from flops.
module sram_port0_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [MASK_W-1:0] wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [MASK_W-1:0] la_wmask_i,
  input  logic [ADDR_W-1:0] la_addr_i,
  input  logic [DATA_W-1:0] la_wdata_i,
  output logic              la_ack_o,
  output logic [DATA_W-1:0] la_rdata_o,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [MASK_W-1:0] sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  input  logic [DATA_W-1:0] sram_dout0
);

  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  state_t            state;
  grant_t            owner;
  logic              op_we;
  logic              live;
  logic [1:0]        lat_cnt;

  logic              wb_active;
  logic              in_window;
  logic              gnt_valid;
  grant_t            gnt;
  logic              owner_req;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic [MASK_W-1:0] sel_mask;
  logic              unused_adr_lsbs;

  assign wb_active       = wbs_cyc_i && wbs_stb_i;
  assign in_window       = (wbs_adr_i[31:11] == BASE_ADDR[31:11]);
  assign unused_adr_lsbs = &{1'b0, wbs_adr_i[1:0]};

  sram_rr_arb2 u_arb (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .en        (state == IDLE),
    .req_wb    (wb_active && in_window),
    .req_la    (la_req_i),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  always_comb begin
    if (gnt == GRANT_WB) begin
      sel_we   = wbs_we_i;
      sel_addr = wbs_adr_i[10:2];
      sel_din  = wbs_dat_i;
      sel_mask = wbs_sel_i;
    end else begin
      sel_we   = la_we_i;
      sel_addr = la_addr_i;
      sel_din  = la_wdata_i;
      sel_mask = la_wmask_i;
    end
  end

  assign owner_req = (owner == GRANT_WB) ? wb_active : la_req_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      owner       <= GRANT_LA;
      op_we       <= 1'b0;
      live        <= 1'b0;
      lat_cnt     <= '0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      la_ack_o    <= 1'b0;
      la_rdata_o  <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      la_ack_o  <= 1'b0;
      wbs_dat_o <= '0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            state       <= ISSUE;
            owner       <= gnt;
            op_we       <= sel_we;
            live        <= 1'b1;
            sram_csb0   <= 1'b0;
            sram_web0   <= ~sel_we;
            sram_addr0  <= sel_addr;
            sram_din0   <= sel_din;
            sram_wmask0 <= issue_mask(sel_we, sel_mask);
          end else if (wb_active && !in_window && !wbs_ack_o) begin
            // Out-of-window hit is answered directly; the guard keeps a
            // master still holding stb during this ack from being re-acked.
            wbs_ack_o <= 1'b1;
          end
        end
        ISSUE: begin
          sram_csb0 <= 1'b1;
          sram_web0 <= 1'b1;
          live      <= live && owner_req;
          lat_cnt   <= '0;
          if (op_we) begin
            state <= ACK;
            if (live && owner_req) begin
              if (owner == GRANT_WB) wbs_ack_o <= 1'b1;
              else                   la_ack_o  <= 1'b1;
            end
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          live <= live && owner_req;
          if (lat_cnt == LAST_CNT) begin
            state <= ACK;
            if (live && owner_req) begin
              if (owner == GRANT_WB) begin
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= sram_dout0;
              end else begin
                la_ack_o   <= 1'b1;
                la_rdata_o <= sram_dout0;
              end
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
